reg_dest_queue: RTL and testbench
=================================

REG_DEST_QUEUE -- requirements
Module: reg_dest_queue

Interface
REQ-001 Parameter ADDR_W, default 5: register-address width in bits.
REQ-002 Parameter DEPTH, default 4: number of outstanding pending writes; SHALL be a power of two, at least 2.
REQ-003 Parameter RA_ADDR, default 31: constant destination for link writes.
REQ-004 Parameter SP_ADDR, default 29: constant destination for stack-pointer writes.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 flush  in  1  synchronous clear of all pending entries.
REQ-008 sel  in  2  destination select: 00=rt, 01=rd, 10=RA_ADDR, 11=SP_ADDR.
REQ-009 rt  in  ADDR_W  rt field of the current instruction.
REQ-010 rd  in  ADDR_W  rd field of the current instruction.
REQ-011 issue_valid  in  1  request to enqueue the selected destination.
REQ-012 issue_ready  out  1  queue can accept an entry this cycle.
REQ-013 wb_valid  in  1  write-back retires the head entry this cycle.
REQ-014 head_valid  out  1  queue non-empty.
REQ-015 head_addr  out  ADDR_W  destination address of the oldest entry.
REQ-016 src_a, src_b  in  ADDR_W  source register addresses being read.
REQ-017 hazard_a, hazard_b  out  1  matching source has a pending write.
REQ-018 count  out  $clog2(DEPTH)+1  number of valid entries.
REQ-019 wb_err  out  1  registered one-cycle pulse on write-back with an empty queue.

Function
REQ-020 Destination mux SHALL use the full ADDR_W width on all inputs and constants; there SHALL be no truncation.
REQ-021 Push occurs when issue_valid and issue_ready are both high; the selected address is written at the tail and count increments.
REQ-022 issue_ready SHALL equal (count < DEPTH), combinational, with no dependency on wb_valid.
REQ-023 Pop occurs when wb_valid and head_valid are both high; the head advances and count decrements.
REQ-024 Simultaneous push and pop SHALL both take effect; count is unchanged and FIFO order is preserved.
REQ-025 Pointers SHALL wrap modulo DEPTH with no bubble at wrap-around.
REQ-026 head_addr and head_valid SHALL be combinational from the storage and count; head_addr is don't-care when head_valid is 0.
REQ-027 wb_valid while empty SHALL leave state unchanged and assert wb_err for exactly the next cycle.
REQ-028 hazard_x SHALL be 1 iff src_x is non-zero and equals the address of any valid entry; the output is combinational with zero latency.
REQ-029 An entry being popped in the current cycle still counts for hazard; an entry being pushed in the current cycle does not.
REQ-030 Address 0 MAY be enqueued, but SHALL never raise a hazard.
REQ-031 flush SHALL empty the queue at the next edge, taking priority over push and pop in the same cycle; wb_err SHALL be 0 in the cycle after a flush.

Reset
REQ-032 On reset assertion, pointers, count, the valid bits and wb_err SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-033 Reset leaves issue_ready=1, head_valid=0, hazard_a=0 and hazard_b=0; storage contents need not be cleared.
REQ-034 Reset asserted mid-operation SHALL discard all pending entries; the first push after deassertion lands at index 0.

Structure
REQ-035 A shared package SHALL hold the sel encodings (SEL_RT, SEL_RD, SEL_RA, SEL_SP) and the default RA/SP address constants.
REQ-036 Storage and pointer logic SHALL live in one sub-module, dest_fifo (parametrised by ADDR_W and DEPTH, exposing per-entry valid bits and addresses).
REQ-037 The select mux and hazard compare SHALL stay in the top module.

Verification
REQ-038 After reset, issue sel=01 with rd=5, then sel=10, then sel=11 -> head_addr=5, count=3; successive pops yield 31 and then 29.
REQ-039 Push 4 entries (DEPTH=4) -> issue_ready=0 and a fifth issue_valid is ignored; then push and pop in the same cycle -> count stays 4 and order is preserved across the pointer wrap.
REQ-040 With pending entry 8 and src_a=8, src_b=0 -> hazard_a=1, hazard_b=0; in the pop cycle hazard_a is still 1, and it is 0 in the following cycle.
REQ-041 Enqueue rt=0 with src_a=0 -> hazard_a=0 and count=1.
REQ-042 wb_valid on an empty queue -> wb_err=1 for exactly one cycle and count stays 0; flush with 3 entries plus a simultaneous push -> count=0 next cycle.
REQ-043 Assert reset asynchronously between edges with 2 entries queued -> count=0 and head_valid=0 before the next edge; the next push lands at index 0.

Source files
------------

// File: rtl/reg_dest_queue_pkg.sv
// rtl/reg_dest_queue_pkg.sv - shared select encodings and default fixed destinations
package reg_dest_queue_pkg;

    localparam logic [1:0] SEL_RT = 2'b00;
    localparam logic [1:0] SEL_RD = 2'b01;
    localparam logic [1:0] SEL_RA = 2'b10;
    localparam logic [1:0] SEL_SP = 2'b11;

    localparam int RA_ADDR_DEF = 31;
    localparam int SP_ADDR_DEF = 29;

endpackage

// File: rtl/reg_dest_queue_dest_fifo.sv
// rtl/reg_dest_queue_dest_fifo.sv - destination storage with per-entry valid bits
module dest_fifo #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           push,
    input  logic                           pop,
    input  logic [ADDR_W-1:0]              din,
    output logic [DEPTH-1:0]               valid,
    output logic [DEPTH-1:0][ADDR_W-1:0]   addrs,
    output logic [ADDR_W-1:0]              head_addr,
    output logic [$clog2(DEPTH):0]         count
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push) begin
                valid[wr_ptr] <= 1'b1;
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) begin
                valid[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            addrs[wr_ptr] <= din;
        end
    end

    assign head_addr = addrs[rd_ptr];

endmodule

// File: rtl/reg_dest_queue.sv
// rtl/reg_dest_queue.sv - pending register-write queue with source hazard detection
module reg_dest_queue
    import reg_dest_queue_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 4,
    parameter int RA_ADDR = RA_ADDR_DEF,
    parameter int SP_ADDR = SP_ADDR_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic [1:0]              sel,
    input  logic [ADDR_W-1:0]       rt,
    input  logic [ADDR_W-1:0]       rd,
    input  logic                    issue_valid,
    output logic                    issue_ready,
    input  logic                    wb_valid,
    output logic                    head_valid,
    output logic [ADDR_W-1:0]       head_addr,
    input  logic [ADDR_W-1:0]       src_a,
    input  logic [ADDR_W-1:0]       src_b,
    output logic                    hazard_a,
    output logic                    hazard_b,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    wb_err
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] RA_C    = ADDR_W'(RA_ADDR);
    localparam logic [ADDR_W-1:0] SP_C    = ADDR_W'(SP_ADDR);

    logic [ADDR_W-1:0]             dest;
    logic                          push;
    logic                          pop;
    logic [DEPTH-1:0]              valid;
    logic [DEPTH-1:0][ADDR_W-1:0]  addrs;

    always_comb begin
        dest = rt;
        case (sel)
            SEL_RT:  dest = rt;
            SEL_RD:  dest = rd;
            SEL_RA:  dest = RA_C;
            SEL_SP:  dest = SP_C;
            default: dest = rt;
        endcase
    end

    assign issue_ready = (count < DEPTH_C);
    assign head_valid  = (count != '0);
    assign push        = issue_valid && issue_ready;
    assign pop         = wb_valid && head_valid;

    dest_fifo #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push),
        .pop       (pop),
        .din       (dest),
        .valid     (valid),
        .addrs     (addrs),
        .head_addr (head_addr),
        .count     (count)
    );

    // Compare against registered valid bits only: a popping entry still hazards, a pushing one not yet.
    always_comb begin
        hazard_a = 1'b0;
        hazard_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && (addrs[i] == src_a)) hazard_a = 1'b1;
            if (valid[i] && (addrs[i] == src_b)) hazard_b = 1'b1;
        end
        if (src_a == '0) hazard_a = 1'b0;
        if (src_b == '0) hazard_b = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_err <= 1'b0;
        end else begin
            wb_err <= wb_valid && !head_valid && !flush;
        end
    end

endmodule

// File: tb/tb_reg_dest_queue.sv
// tb/tb_reg_dest_queue.sv - directed vector bench for reg_dest_queue
module tb_reg_dest_queue;

    logic       clk;
    logic       reset;
    logic       flush;
    logic [1:0] sel;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       issue_valid;
    logic       issue_ready;
    logic       wb_valid;
    logic       head_valid;
    logic [4:0] head_addr;
    logic [4:0] src_a;
    logic [4:0] src_b;
    logic       hazard_a;
    logic       hazard_b;
    logic [2:0] count;
    logic       wb_err;

    int errors = 0;
    int checks = 0;

    reg_dest_queue #(
        .ADDR_W  (5),
        .DEPTH   (4),
        .RA_ADDR (31),
        .SP_ADDR (29)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .sel         (sel),
        .rt          (rt),
        .rd          (rd),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .wb_valid    (wb_valid),
        .head_valid  (head_valid),
        .head_addr   (head_addr),
        .src_a       (src_a),
        .src_b       (src_b),
        .hazard_a    (hazard_a),
        .hazard_b    (hazard_b),
        .count       (count),
        .wb_err      (wb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       fl;
        logic [1:0] sel;
        logic [4:0] rt;
        logic [4:0] rd;
        logic       iv;
        logic       wb;
        logic [4:0] sa;
        logic [4:0] sb;
        logic       rdy;
        logic       hv;
        logic [4:0] ha;
        logic [2:0] cnt;
        logic       hza;
        logic       hzb;
        logic       err;
    } vec_t;

    localparam int NV = 41;
    vec_t tbl[NV];

    function automatic vec_t v(input logic fl, input logic [1:0] s, input int t, input int d,
                               input logic iv, input logic wb, input int sa, input int sb,
                               input logic rdy, input logic hv, input int ha, input int cnt,
                               input logic hza, input logic hzb, input logic err);
        vec_t r;
        r.fl = fl; r.sel = s; r.rt = 5'(t); r.rd = 5'(d); r.iv = iv; r.wb = wb;
        r.sa = 5'(sa); r.sb = 5'(sb); r.rdy = rdy; r.hv = hv; r.ha = 5'(ha);
        r.cnt = 3'(cnt); r.hza = hza; r.hzb = hzb; r.err = err;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %0d, expected %0d", name, idx, act, exp);
        end
    endtask

    task automatic drive_idle();
        flush = 0; sel = 2'b00; rt = 0; rd = 0; issue_valid = 0; wb_valid = 0;
        src_a = 0; src_b = 0;
    endtask

    initial begin
        clk = 0;
        reset = 1;
        drive_idle();

        //           fl sel   rt  rd iv wb sa  sb | rdy hv ha  cnt hza hzb err
        tbl[0]  = v(0, 2'b00, 0,  0, 0, 0, 0,  0,   1,  0, 0,  0,  0,  0,  0);
        tbl[1]  = v(0, 2'b01, 7,  5, 1, 0, 0,  0,   1,  0, 0,  0,  0,  0,  0);
        tbl[2]  = v(0, 2'b10, 7,  5, 1, 0, 0,  0,   1,  1, 5,  1,  0,  0,  0);
        tbl[3]  = v(0, 2'b11, 7,  5, 1, 0, 0,  0,   1,  1, 5,  2,  0,  0,  0);
        tbl[4]  = v(0, 2'b00, 0,  0, 0, 0, 31, 29,  1,  1, 5,  3,  1,  1,  0);
        tbl[5]  = v(0, 2'b00, 0,  0, 0, 1, 5,  0,   1,  1, 5,  3,  1,  0,  0);
        tbl[6]  = v(0, 2'b00, 0,  0, 0, 1, 5,  31,  1,  1, 31, 2,  0,  1,  0);
        tbl[7]  = v(0, 2'b00, 0,  0, 0, 1, 0,  0,   1,  1, 29, 1,  0,  0,  0);
        tbl[8]  = v(0, 2'b00, 0,  0, 0, 0, 0,  0,   1,  0, 0,  0,  0,  0,  0);
        tbl[9]  = v(0, 2'b00, 0,  0, 0, 1, 0,  0,   1,  0, 0,  0,  0,  0,  0);
        tbl[10] = v(0, 2'b00, 0,  0, 0, 0, 0,  0,   1,  0, 0,  0,  0,  0,  1);
        tbl[11] = v(0, 2'b00, 0,  0, 0, 0, 0,  0,   1,  0, 0,  0,  0,  0,  0);
        tbl[12] = v(0, 2'b00, 8,  3, 1, 0, 0,  0,   1,  0, 0,  0,  0,  0,  0);
        tbl[13] = v(0, 2'b00, 9,  3, 1, 0, 0,  0,   1,  1, 8,  1,  0,  0,  0);
        tbl[14] = v(0, 2'b00, 10, 3, 1, 0, 0,  0,   1,  1, 8,  2,  0,  0,  0);
        tbl[15] = v(0, 2'b00, 11, 3, 1, 0, 0,  0,   1,  1, 8,  3,  0,  0,  0);
        tbl[16] = v(0, 2'b00, 12, 3, 1, 0, 0,  0,   0,  1, 8,  4,  0,  0,  0);
        tbl[17] = v(0, 2'b00, 0,  0, 0, 0, 12, 11,  0,  1, 8,  4,  0,  1,  0);
        tbl[18] = v(0, 2'b00, 0,  0, 0, 1, 0,  0,   0,  1, 8,  4,  0,  0,  0);
        tbl[19] = v(0, 2'b00, 12, 0, 1, 1, 0,  0,   1,  1, 9,  3,  0,  0,  0);
        tbl[20] = v(0, 2'b00, 13, 0, 1, 1, 0,  0,   1,  1, 10, 3,  0,  0,  0);
        tbl[21] = v(0, 2'b00, 14, 0, 1, 0, 0,  0,   1,  1, 11, 3,  0,  0,  0);
        tbl[22] = v(0, 2'b00, 0,  0, 0, 1, 14, 0,   0,  1, 11, 4,  1,  0,  0);
        tbl[23] = v(0, 2'b00, 0,  0, 0, 1, 0,  0,   1,  1, 12, 3,  0,  0,  0);
        tbl[24] = v(0, 2'b00, 0,  0, 0, 1, 0,  0,   1,  1, 13, 2,  0,  0,  0);
        tbl[25] = v(0, 2'b00, 0,  0, 0, 1, 0,  0,   1,  1, 14, 1,  0,  0,  0);
        tbl[26] = v(0, 2'b00, 0,  0, 0, 0, 14, 0,   1,  0, 0,  0,  0,  0,  0);
        tbl[27] = v(0, 2'b00, 8,  0, 1, 0, 8,  0,   1,  0, 0,  0,  0,  0,  0);
        tbl[28] = v(0, 2'b00, 0,  0, 0, 0, 8,  0,   1,  1, 8,  1,  1,  0,  0);
        tbl[29] = v(0, 2'b00, 0,  0, 0, 1, 8,  0,   1,  1, 8,  1,  1,  0,  0);
        tbl[30] = v(0, 2'b00, 0,  0, 0, 0, 8,  0,   1,  0, 0,  0,  0,  0,  0);
        tbl[31] = v(0, 2'b00, 0,  6, 1, 0, 0,  0,   1,  0, 0,  0,  0,  0,  0);
        tbl[32] = v(0, 2'b00, 0,  0, 0, 0, 0,  6,   1,  1, 0,  1,  0,  0,  0);
        tbl[33] = v(0, 2'b00, 0,  0, 0, 1, 0,  0,   1,  1, 0,  1,  0,  0,  0);
        tbl[34] = v(0, 2'b00, 1,  0, 1, 0, 0,  0,   1,  0, 0,  0,  0,  0,  0);
        tbl[35] = v(0, 2'b00, 2,  0, 1, 0, 0,  0,   1,  1, 1,  1,  0,  0,  0);
        tbl[36] = v(0, 2'b00, 3,  0, 1, 0, 0,  0,   1,  1, 1,  2,  0,  0,  0);
        tbl[37] = v(1, 2'b00, 4,  0, 1, 1, 3,  0,   1,  1, 1,  3,  1,  0,  0);
        tbl[38] = v(0, 2'b00, 0,  0, 0, 0, 3,  4,   1,  0, 0,  0,  0,  0,  0);
        tbl[39] = v(1, 2'b00, 0,  0, 0, 1, 0,  0,   1,  0, 0,  0,  0,  0,  0);
        tbl[40] = v(0, 2'b00, 0,  0, 0, 0, 0,  0,   1,  0, 0,  0,  0,  0,  0);

        #12 reset = 0;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            flush = tbl[i].fl; sel = tbl[i].sel; rt = tbl[i].rt; rd = tbl[i].rd;
            issue_valid = tbl[i].iv; wb_valid = tbl[i].wb;
            src_a = tbl[i].sa; src_b = tbl[i].sb;
            #2;
            chk("issue_ready", i, int'(issue_ready), int'(tbl[i].rdy));
            chk("head_valid",  i, int'(head_valid),  int'(tbl[i].hv));
            if (tbl[i].hv) chk("head_addr", i, int'(head_addr), int'(tbl[i].ha));
            chk("count",       i, int'(count),       int'(tbl[i].cnt));
            chk("hazard_a",    i, int'(hazard_a),    int'(tbl[i].hza));
            chk("hazard_b",    i, int'(hazard_b),    int'(tbl[i].hzb));
            chk("wb_err",      i, int'(wb_err),      int'(tbl[i].err));
            @(posedge clk); #1;
        end

        // Asynchronous reset between edges with two entries pending.
        drive_idle();
        issue_valid = 1; rt = 21;
        @(posedge clk); #1;
        rt = 22;
        @(posedge clk); #1;
        drive_idle();
        #2;
        chk("pre_reset_count", 100, int'(count), 2);
        #1 reset = 1;
        #1;
        chk("async_count",      101, int'(count),       0);
        chk("async_head_valid", 101, int'(head_valid),  0);
        chk("async_ready",      101, int'(issue_ready), 1);
        #2 reset = 0;
        @(posedge clk); #1;
        issue_valid = 1; rt = 23;
        @(posedge clk); #1;
        drive_idle();
        #2;
        chk("post_reset_count", 102, int'(count),             1);
        chk("post_reset_head",  102, int'(head_addr),         23);
        chk("post_reset_index", 102, int'(dut.u_fifo.valid),  1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
